hilo_muldiv_ctrl: RTL
=====================

Name: hilo_muldiv_ctrl

Overview:
Iterative multiply/divide sequencer that owns the HI/LO register pair for the MULT/MULTU/DIV/DIVU/MFHI/MFLO group recognised by the decode stage. It accepts one operation from decode, runs a 32-step shift-add or restoring-divide loop, and writes HI/LO. It stalls MFHI/MFLO reads until the result is valid. It sits beside the execute stage, and decode holds issue while it is busy.

Parameters:
WIDTH, 32, operand and HI/LO width; only 32 is supported.
STEPS, 32, iteration count; must equal WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous reset, active low
start  in  1  issue request from decode, sampled on the clk edge
op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
rs_val  in  WIDTH  operand A (multiplicand or dividend)
rt_val  in  WIDTH  operand B (multiplier or divisor)
busy  out  1  operation in flight; decode must not issue
done  out  1  one-cycle pulse in the cycle HI/LO first show the new result
rd_req  in  1  MFHI/MFLO read request
rd_sel  in  1  0=LO, 1=HI
rd_data  out  WIDTH  selected HI or LO, combinational
rd_stall  out  1  read result not valid this cycle; requester holds

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset value of every output: busy=0, done=0, rd_stall=0, rd_data=0. Internally HI=0, LO=0, state=IDLE.
- Vectors are numbered with bit 0 as the MSB, matching the decode datapath.
- State machine: IDLE -> CALC -> FIX -> IDLE.
  - IDLE, start=1 at edge E0: latch op and operands. For signed ops, store the operand magnitudes and the sign flags. Clear the step counter. Go to CALC.
  - CALC: one iteration per edge, E1..E32. Multiply: shift-add into a 64-bit accumulator. Divide: restoring, one quotient bit per step. At E32 go to FIX.
  - FIX, edge E33: apply sign correction, write HI/LO, go to IDLE, assert done.
- Timing:
  - busy=1 in the cycles following E0 through E32. It is 0 in the done cycle.
  - done=1 for exactly the cycle following E33.
  - Total latency: 34 edges from start sample to result visible.
- Results:
  - Multiply: {HI,LO} = 64-bit product. Signed when op=MULT: product is negated if the operand signs differ.
  - Divide: LO = quotient, HI = remainder.
  - DIV: quotient is negative if the signs differ; the remainder takes the dividend's sign. Truncation is toward zero.
- Boundary conditions:
  - Divide by zero (rt_val=0): LO=32'hFFFFFFFF, HI=rs_val, with no sign correction. Still 34 edges and still pulses done.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (natural wrap, no trap).
  - start while busy=1 or in FIX: ignored, no state change. Decode is responsible for holding the request.
  - start and rd_req in the same cycle while IDLE: read returns the old HI/LO with rd_stall=0, and the operation is accepted.
  - rd_req while busy=1 or in FIX: rd_stall=1. rd_data is don't-care.
  - rd_req in the done cycle: rd_stall=0 and rd_data shows the new value.
  - rd_stall is 0 whenever rd_req=0.
- Reset asserted mid-operation: everything returns to reset values immediately and asynchronously. The partial result is discarded and no done pulse occurs. After release, the next start runs a full 34-edge operation.
- HI/LO are written only in FIX; no other path modifies them.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done exactly 34 edges after start; HI=0xFFFFFFFE, LO=0x00000001; busy high for 33 cycles.
2. MULT 0xFFFFFFFD (-3) x 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
3. DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 2 -> LO=3, HI=1.
4. DIVU 0x00000064 / 0 -> LO=0xFFFFFFFF, HI=0x00000064, done after 34 edges. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
5. Issue MULTU 6 x 7, hold rd_req=1, rd_sel=0 from the next cycle -> rd_stall=1 every busy/FIX cycle; in the done cycle rd_stall=0 and rd_data=0x0000002A. A second start pulsed at cycle 5 is ignored, with HI=0.
6. Start DIVU 100/3, deassert rst_n at cycle 10 -> busy, done, HI and LO are all 0 at once with no done pulse. After release, DIVU 100/3 -> LO=33, HI=1 after 34 edges.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU: 32-step shift-add / restoring-divide sequencer.
// Latency 34 edges start->done; start ignored while busy, MFHI/MFLO reads stall until result valid.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [0:1]       op,
    input  logic [0:WIDTH-1] rs_val,
    input  logic [0:WIDTH-1] rt_val,
    output logic             busy,
    output logic             done,
    input  logic             rd_req,
    input  logic             rd_sel,
    output logic [0:WIDTH-1] rd_data,
    output logic             rd_stall
);

    localparam int CW = $clog2(STEPS);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_main_q, neg_main_d;
    logic               neg_rem_q, neg_rem_d;
    logic               done_q, done_d;

    logic [1:0]         op_w;
    logic [WIDTH-1:0]   rs_w, rt_w;
    logic               signed_op, op_div, rs_neg, rt_neg;
    logic [WIDTH:0]     add_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;

    // Re-index the MSB-at-bit-0 ports into conventional descending vectors.
    assign op_w = op;
    assign rs_w = rs_val;
    assign rt_w = rt_val;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opb_d      = opb_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        done_d     = 1'b0;

        signed_op = ~op_w[0];
        op_div    = op_w[1];
        rs_neg    = rs_w[WIDTH-1];
        rt_neg    = rt_w[WIDTH-1];

        add_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        prod_mag = {acc_hi_q, acc_lo_q};
        prod_fix = neg_main_q ? (~prod_mag + 1'b1) : prod_mag;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CALC;
                    is_div_d = op_div;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    // Divide by zero runs raw operands unsigned: the loop then yields
                    // all-ones quotient and the dividend as remainder, uncorrected.
                    if (op_div && (rt_w == '0)) begin
                        acc_lo_d   = rs_w;
                        opb_d      = '0;
                        neg_main_d = 1'b0;
                        neg_rem_d  = 1'b0;
                    end else begin
                        acc_lo_d   = (signed_op && rs_neg) ? (~rs_w + 1'b1) : rs_w;
                        opb_d      = (signed_op && rt_neg) ? (~rt_w + 1'b1) : rt_w;
                        neg_main_d = signed_op && (rs_neg ^ rt_neg);
                        neg_rem_d  = signed_op && rs_neg;
                    end
                end
            end
            CALC: begin
                if (is_div_q) begin
                    acc_hi_d = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
                end else begin
                    {acc_hi_d, acc_lo_d} = {add_sum, acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = neg_main_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
                    hi_d = neg_rem_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opb_q      <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opb_q      <= opb_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rd_stall = rd_req && (state_q != IDLE);
    assign rd_data  = rd_sel ? hi_q : lo_q;

endmodule
